// File: rtl/uhci_frame_timer.sv
// UHCI frame timer: SOF strobes, pre-SOF window, frame number and frame-list index,
// with run-time frame trim, per-port SOF gating and overrun detection/halt.
module uhci_frame_timer #(
  parameter int FRAME_BASE     = 11936,
  parameter int SOFMOD_W       = 7,
  parameter int FRAME_W        = 14,
  parameter int PRE_SOF_CYCLES = 100,
  parameter int FN_W           = 11,
  parameter int FLI_W          = 4,
  parameter int NUM_PORTS      = 2
) (
  input  logic                 UHCI_clk,
  input  logic                 rst,
  input  logic                 RS,
  input  logic                 TD_done,
  input  logic [SOFMOD_W-1:0]  sof_mod,
  input  logic                 fn_wr_en,
  input  logic [FN_W-1:0]      fn_wr_data,
  input  logic                 overrun_halt_en,
  input  logic                 clear_halt,
  input  logic [NUM_PORTS-1:0] port_en,
  output logic                 sof,
  output logic [NUM_PORTS-1:0] sof_port,
  output logic                 pre_sof,
  output logic [FN_W-1:0]      frame_num,
  output logic [FLI_W-1:0]     frame_list_index,
  output logic                 hc_halted,
  output logic                 HCR_halt_sof,
  output logic                 overrun
);

  typedef enum logic [1:0] {STOPPED, RUNNING, HALTED} state_t;

  localparam logic [FRAME_W-1:0] BASE_M1 = FRAME_W'(FRAME_BASE - 1);
  localparam logic [FRAME_W-1:0] PRE_LIM = FRAME_W'(PRE_SOF_CYCLES);

  state_t             state;
  logic [FRAME_W-1:0] cnt;
  logic               td_pending;
  logic [FRAME_W-1:0] reload;
  logic [FRAME_W-1:0] cnt_dec;
  logic               pend;

  // Reload is L-1 so the next SOF lands exactly L clocks after this one.
  assign reload           = BASE_M1 + FRAME_W'(sof_mod);
  assign cnt_dec          = cnt - FRAME_W'(1);
  // A TD_done coinciding with the frame's last clock still counts for that frame.
  assign pend             = td_pending & ~TD_done;
  assign frame_list_index = frame_num[FLI_W-1:0];

  always_ff @(posedge UHCI_clk) begin
    if (rst) begin
      state        <= STOPPED;
      cnt          <= '0;
      td_pending   <= 1'b0;
      sof          <= 1'b0;
      sof_port     <= '0;
      pre_sof      <= 1'b0;
      frame_num    <= '0;
      hc_halted    <= 1'b1;
      HCR_halt_sof <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sof      <= 1'b0;
      sof_port <= '0;
      pre_sof  <= 1'b0;
      case (state)
        STOPPED: begin
          if (fn_wr_en) frame_num <= fn_wr_data;
          if (RS) begin
            state      <= RUNNING;
            sof        <= 1'b1;
            sof_port   <= port_en;
            cnt        <= reload;
            td_pending <= 1'b1;
            hc_halted  <= 1'b0;
          end
        end
        RUNNING: begin
          if (cnt != '0) begin
            cnt        <= cnt_dec;
            td_pending <= pend;
            pre_sof    <= (cnt_dec < PRE_LIM);
          end else if (!RS) begin
            state      <= STOPPED;
            hc_halted  <= 1'b1;
            td_pending <= 1'b0;
          end else if (pend && overrun_halt_en) begin
            state        <= HALTED;
            HCR_halt_sof <= 1'b1;
            overrun      <= 1'b1;
            hc_halted    <= 1'b1;
          end else begin
            sof        <= 1'b1;
            sof_port   <= port_en;
            frame_num  <= frame_num + FN_W'(1);
            cnt        <= reload;
            td_pending <= 1'b1;
            if (pend) overrun <= 1'b1;
          end
        end
        HALTED: begin
          if (fn_wr_en) frame_num <= fn_wr_data;
          if (clear_halt && !RS) begin
            state        <= STOPPED;
            HCR_halt_sof <= 1'b0;
          end
        end
        default: state <= STOPPED;
      endcase
    end
  end

endmodule
